// File: rtl/onets_led_pkg.sv
// Shared mode encoding for the status-LED driver.
package onets_led_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] LED_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] LED_ON    = 2'd1;
    localparam logic [MODE_W-1:0] LED_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] LED_ACT   = 2'd3;

endpackage

// File: rtl/onets_led_stretch.sv
// One LED channel: activity pulse-stretch counter and base-level select.
module onets_led_stretch
    import onets_led_pkg::*;
#(
    parameter int STRETCH_TICKS = 50
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              act,
    input  logic              tick,
    input  logic              blink,
    output logic              base
);

    localparam int SW = $clog2(STRETCH_TICKS + 1);
    localparam logic [SW-1:0] LOAD_VAL = SW'(STRETCH_TICKS);

    logic [SW-1:0] stretch_q, stretch_d;

    // A fresh event reloads the full stretch even if a tick lands on the same cycle.
    always_comb begin
        stretch_d = stretch_q;
        if (mode != LED_ACT) begin
            stretch_d = '0;
        end else if (act) begin
            stretch_d = LOAD_VAL;
        end else if (tick && (stretch_q != '0)) begin
            stretch_d = stretch_q - SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stretch_q <= '0;
        end else begin
            stretch_q <= stretch_d;
        end
    end

    always_comb begin
        base = 1'b0;
        case (mode)
            LED_OFF:   base = 1'b0;
            LED_ON:    base = 1'b1;
            LED_BLINK: base = blink;
            LED_ACT:   base = (stretch_q != '0);
            default:   base = 1'b0;
        endcase
    end

endmodule

// File: rtl/onets_led_driver.sv
// Multi-channel status-LED driver: shared prescaler/blink counter, per-channel
// off/on/blink/activity modes. Define ONETS_LED_PWM_EN for global PWM dimming.
module onets_led_driver
    import onets_led_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int TICK_DIV      = 125000,
    parameter int BLINK_W       = 9,
    parameter int STRETCH_TICKS = 50,
    parameter int PWM_W         = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [MODE_W*NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0]        act,
`ifdef ONETS_LED_PWM_EN
    input  logic [PWM_W-1:0]         brightness,
`endif
    output logic [NUM_CH-1:0]        led_out,
    output logic                     tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               tick_q;
    logic [NUM_CH-1:0]  led_q, led_d;
    logic [NUM_CH-1:0]  base;
    logic               tick;
    logic               gate;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        blink_d = tick ? blink_q + BLINK_W'(1) : blink_q;
    end

`ifdef ONETS_LED_PWM_EN
    logic [PWM_W-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = pwm_q + PWM_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign gate = (pwm_q < brightness);
`else
    assign gate = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        onets_led_stretch #(
            .STRETCH_TICKS (STRETCH_TICKS)
        ) u_stretch (
            .clk     (clk),
            .reset_n (reset_n),
            .mode    (mode[MODE_W*i +: MODE_W]),
            .act     (act[i]),
            .tick    (tick),
            .blink   (blink_q[BLINK_W-1]),
            .base    (base[i])
        );
    end

    always_comb begin
        led_d = base & {NUM_CH{gate}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            blink_q <= '0;
            tick_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
            tick_q  <= tick;
            led_q   <= led_d;
        end
    end

    assign led_out = led_q;
    assign tick_o  = tick_q;

endmodule

// File: tb/tb_onets_led_driver.sv
// Randomised self-checking bench for onets_led_driver against an edge-count model.
module tb_onets_led_driver;

    localparam int NUM_CH        = 4;
    localparam int TICK_DIV      = 4;
    localparam int BLINK_W       = 3;
    localparam int STRETCH_TICKS = 3;
    localparam int PWM_W         = 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [2*NUM_CH-1:0] mode = '0;
    logic [NUM_CH-1:0]   act = '0;
`ifdef ONETS_LED_PWM_EN
    logic [PWM_W-1:0]    brightness = '1;
`endif
    logic [NUM_CH-1:0]   led_out;
    logic                tick_o;

    onets_led_driver #(
        .NUM_CH        (NUM_CH),
        .TICK_DIV      (TICK_DIV),
        .BLINK_W       (BLINK_W),
        .STRETCH_TICKS (STRETCH_TICKS),
        .PWM_W         (PWM_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .act        (act),
`ifdef ONETS_LED_PWM_EN
        .brightness (brightness),
`endif
        .led_out    (led_out),
        .tick_o     (tick_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: ecnt = active edges since reset release; last_act = edge of latest ACT event.
    int                ecnt = 0;
    int                last_act [NUM_CH];
    bit                last_ok  [NUM_CH];
    logic [NUM_CH-1:0] exp_led;
    logic              exp_tick;

    task automatic model_clear();
        ecnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            last_ok[i]  = 1'b0;
            last_act[i] = 0;
        end
    endtask

    // Advance one edge, then compute what the outputs must be after that edge.
    task automatic cycle();
        int m;
        bit b;
        int period_blink;
        @(posedge clk);
        ecnt++;
        #1;
        period_blink = 1 << BLINK_W;
        for (int i = 0; i < NUM_CH; i++) begin
            m = int'(mode[2*i +: 2]);
            case (m)
                0: b = 1'b0;
                1: b = 1'b1;
                2: b = (((ecnt - 1) / TICK_DIV) % period_blink) >= (period_blink / 2);
                default: b = last_ok[i] &&
                             ((((ecnt - 1) / TICK_DIV) - (last_act[i] / TICK_DIV)) < STRETCH_TICKS);
            endcase
`ifdef ONETS_LED_PWM_EN
            b = b && (((ecnt - 1) % (1 << PWM_W)) < int'(brightness));
`endif
            exp_led[i] = b;
            if (m != 3) begin
                last_ok[i] = 1'b0;
            end else if (act[i]) begin
                last_ok[i]  = 1'b1;
                last_act[i] = ecnt;
            end
        end
        exp_tick = (ecnt >= TICK_DIV) && ((ecnt % TICK_DIV) == 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mode = '0;
        act = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (led_out !== '0) begin
            n_bad++;
            $display("FAIL reset_led: got %b want 0000", led_out);
        end
        n_cmp++;
        if (tick_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick: got %b want 0", tick_o);
        end
        release_reset();
        for (int k = 0; k < 14; k++) begin
            cycle();
            n_cmp++;
            if (led_out !== exp_led || tick_o !== exp_tick) begin
                n_bad++;
                $display("FAIL reset_tick_seq: cyc %0d led %b tick %b want led %b tick %b",
                         ecnt, led_out, tick_o, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_modes();
        mode = {2'd3, 2'd2, 2'd1, 2'd0};
        act = '0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            n_cmp++;
            if (led_out !== exp_led || tick_o !== exp_tick) begin
                n_bad++;
                $display("FAIL modes: cyc %0d led %b tick %b want led %b tick %b",
                         ecnt, led_out, tick_o, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_act_single();
        mode = {2'd3, 2'd0, 2'd0, 2'd0};
        act = '0;
        // single pulse away from a tick, then one landing on a tick edge
        for (int pass = 0; pass < 2; pass++) begin
            while (((ecnt + 1) % TICK_DIV) != (pass == 0 ? 2 : 0)) begin
                cycle();
                n_cmp++;
                if (led_out !== exp_led || tick_o !== exp_tick) begin
                    n_bad++;
                    $display("FAIL act_align: cyc %0d led %b want %b", ecnt, led_out, exp_led);
                end
            end
            act[3] = 1'b1;
            cycle();
            act[3] = 1'b0;
            for (int k = 0; k < 20; k++) begin
                cycle();
                n_cmp++;
                if (led_out !== exp_led || tick_o !== exp_tick) begin
                    n_bad++;
                    $display("FAIL act_single: pass %0d cyc %0d led %b tick %b want led %b tick %b",
                             pass, ecnt, led_out, tick_o, exp_led, exp_tick);
                end
            end
        end
    endtask

    task automatic test_leave_act();
        mode = {2'd3, 2'd0, 2'd0, 2'd0};
        act[3] = 1'b1;
        cycle();
        act[3] = 1'b0;
        cycle();
        n_cmp++;
        if (led_out[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL leave_act_lit: got %b want 1", led_out[3]);
        end
        act[3] = 1'b1;
        cycle();
        act[3] = 1'b0;
        mode = '0;
        cycle();
        n_cmp++;
        if (led_out[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL leave_act_off: got %b want 0", led_out[3]);
        end
        mode = {2'd3, 2'd0, 2'd0, 2'd0};
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_cmp++;
            if (led_out !== exp_led || led_out[3] !== 1'b0) begin
                n_bad++;
                $display("FAIL leave_act_return: cyc %0d led %b want %b", ecnt, led_out, exp_led);
            end
        end
    endtask

    task automatic test_reset_mid();
        mode = {2'd3, 2'd2, 2'd1, 2'd0};
        act[3] = 1'b1;
        for (int k = 0; k < 21; k++) cycle();
        act[3] = 1'b0;
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (led_out !== '0 || tick_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: led %b tick %b want 0000/0", led_out, tick_o);
        end
        release_reset();
        for (int k = 0; k < 40; k++) begin
            cycle();
            n_cmp++;
            if (led_out !== exp_led || tick_o !== exp_tick) begin
                n_bad++;
                $display("FAIL reset_mid_restart: cyc %0d led %b tick %b want led %b tick %b",
                         ecnt, led_out, tick_o, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) mode = 8'($urandom);
            for (int i = 0; i < NUM_CH; i++) act[i] = ($urandom_range(5) == 0);
`ifdef ONETS_LED_PWM_EN
            if ($urandom_range(15) == 0) brightness = PWM_W'($urandom);
`endif
            cycle();
            n_cmp++;
            if (led_out !== exp_led || tick_o !== exp_tick) begin
                n_bad++;
                $display("FAIL random: cyc %0d mode %h act %b led %b tick %b want led %b tick %b",
                         ecnt, mode, act, led_out, tick_o, exp_led, exp_tick);
            end
        end
        act = '0;
    endtask

`ifdef ONETS_LED_PWM_EN
    task automatic test_pwm();
        int lit;
        logic [PWM_W-1:0] levels [3];
        levels[0] = 2'd1;
        levels[1] = 2'd0;
        levels[2] = 2'd3;
        mode = 8'b01_01_01_01;
        act = '0;
        for (int j = 0; j < 3; j++) begin
            brightness = levels[j];
            cycle();
            lit = 0;
            for (int k = 0; k < 16; k++) begin
                cycle();
                if (led_out[0]) lit++;
                n_cmp++;
                if (led_out !== exp_led) begin
                    n_bad++;
                    $display("FAIL pwm: bright %0d cyc %0d led %b want %b",
                             brightness, ecnt, led_out, exp_led);
                end
            end
            n_cmp++;
            if (lit != 4 * int'(levels[j])) begin
                n_bad++;
                $display("FAIL pwm_duty: bright %0d lit %0d of 16 want %0d",
                         levels[j], lit, 4 * int'(levels[j]));
            end
        end
        brightness = '1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_modes();
        test_act_single();
        test_leave_act();
        test_reset_mid();
        test_random();
`ifdef ONETS_LED_PWM_EN
        test_pwm();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
